// File: rtl/apb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb_arbiter_pkg
//   Shared types and width helpers for the APB arbiter slice.
//   - arb_state_e : slave-side phase sequencer states (IDLE / SETUP / ACCESS)
//   - idx_width() : width of a master index (minimum 1 bit)
//   - tmo_width() : width of the ACCESS watchdog counter, able to hold the limit
// ---------------------------------------------------------------------------
package apb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tmo_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: returns the first asserted request
//   at or after ptr, searching cyclically. The pointer register is owned by
//   the parent so that it only advances when a transfer actually completes.
//
//   Ports
//     req        in   NUM_REQ   request vector
//     ptr        in   IDX_W     highest-priority index for this pick
//     pick_idx   out  IDX_W     chosen index (0 when nothing requests)
//     pick_valid out  1         at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       sum;

  // Rotating the doubled vector right by ptr puts request (ptr+k) mod N at
  // bit k, so the lowest set bit of req_rot is the round-robin winner.
  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    req_dbl    = {req, req};
    req_rot    = NUM_REQ'(req_dbl >> ptr);
    sum        = '0;
    pick_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum        = {1'b0, ptr} + (IDX_W+1)'(k);
        pick_valid = 1'b1;
      end
    end
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      sum = sum - (IDX_W+1)'(NUM_REQ);
    end
    pick_idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//   Shares one downstream APB slave port among NUM_MASTERS upstream masters.
//   Round-robin grant in IDLE, then one SETUP and one or more ACCESS cycles on
//   the slave side. Only the granted master sees PREADY/PSLVERR/PRDATA; all
//   others stall with PREADY low.
//
//   Optional feature (macro APB_ARBITER_TIMEOUT_EN): an ACCESS watchdog that
//   force-completes the transfer with an error after TIMEOUT_CYCLES wait
//   cycles. Without the macro ACCESS waits for s_pready indefinitely.
//
//   Ports
//     PCLK, PRESET                  clock, asynchronous active-high reset
//     m_psel/m_penable/m_pwrite     per-master APB control (NUM_MASTERS each)
//     m_paddr, m_pwdata             packed per-master address / write data
//     m_prdata                      shared read data (valid with m_pready)
//     m_pready, m_pslverr           per-master response
//     s_psel ... s_pwdata           slave-side request
//     s_prdata, s_pready, s_pslverr slave-side response
//     grant_valid, grant_idx        ownership status (SETUP or ACCESS)
// ---------------------------------------------------------------------------
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int APB_ADDR_WIDTH = 13,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  PCLK,
  input  logic                                  PRESET,
  input  logic [NUM_MASTERS-1:0]                m_psel,
  input  logic [NUM_MASTERS-1:0]                m_penable,
  input  logic [NUM_MASTERS-1:0]                m_pwrite,
  input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0] m_paddr,
  input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0] m_pwdata,
  output logic [APB_DATA_WIDTH-1:0]             m_prdata,
  output logic [NUM_MASTERS-1:0]                m_pready,
  output logic [NUM_MASTERS-1:0]                m_pslverr,
  output logic                                  s_psel,
  output logic                                  s_penable,
  output logic                                  s_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]             s_paddr,
  output logic [APB_DATA_WIDTH-1:0]             s_pwdata,
  input  logic [APB_DATA_WIDTH-1:0]             s_prdata,
  input  logic                                  s_pready,
  input  logic                                  s_pslverr,
  output logic                                  grant_valid,
  output logic [idx_width(NUM_MASTERS)-1:0]     grant_idx
);

  localparam int AW    = APB_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int IDX_W = idx_width(NUM_MASTERS);

  arb_state_e       state, state_next;
  logic [IDX_W-1:0] rr_ptr, grant_r, pick_idx, ptr_after;
  logic             pick_valid, xfer_done, tmo_hit;

  // Signals of the currently granted master.
  logic             sel_psel, sel_pwrite;
  logic [AW-1:0]    sel_paddr;
  logic [DW-1:0]    sel_pwdata;

  rr_arbiter #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (m_psel),
    .ptr        (rr_ptr),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_comb begin
    sel_psel   = 1'b0;
    sel_pwrite = 1'b0;
    sel_paddr  = '0;
    sel_pwdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_r == IDX_W'(i)) begin
        sel_psel   = m_psel[i];
        sel_pwrite = m_pwrite[i];
        sel_paddr  = m_paddr[i*AW +: AW];
        sel_pwdata = m_pwdata[i*DW +: DW];
      end
    end
  end

  assign ptr_after = (grant_r == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_r + 1'b1;

`ifdef APB_ARBITER_TIMEOUT_EN
  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts ACCESS cycles that ended without s_pready; cleared outside ACCESS
  // so every transfer starts its watchdog from zero.
  assign tmo_hit = (state == ST_ACCESS) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tmo_cnt <= '0;
    end else if (state == ST_ACCESS && !s_pready && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign xfer_done = (state == ST_ACCESS) && (s_pready || tmo_hit);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      grant_r <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && pick_valid) begin
        grant_r <= pick_idx;
      end
      if (xfer_done) begin
        rr_ptr <= ptr_after;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (pick_valid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (xfer_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // A granted master that has dropped PSEL still gets its slave transfer
  // finished, but the response is withheld from it.
  always_comb begin
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    m_prdata  = '0;
    m_pready  = '0;
    m_pslverr = '0;
    if (state != ST_IDLE) begin
      s_psel    = 1'b1;
      s_penable = (state == ST_ACCESS);
      s_pwrite  = sel_pwrite;
      s_paddr   = sel_paddr;
      s_pwdata  = sel_pwdata;
    end
    if (state == ST_ACCESS) begin
      m_prdata = s_prdata;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant_r == IDX_W'(i)) begin
          m_pready[i]  = sel_psel & (s_pready | tmo_hit);
          m_pslverr[i] = sel_psel & ((s_pready & s_pslverr) | tmo_hit);
        end
      end
    end
  end

  assign grant_valid = (state != ST_IDLE);
  assign grant_idx   = grant_r;

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
//   Self-checking bench for apb_arbiter (2 masters, 13-bit address, 32-bit
//   data). Directed table of single transfers, hand sequences for protocol
//   corner cases, and a randomized traffic engine checked against a
//   round-robin/memory reference model. Timeout sequence runs only when
//   APB_ARBITER_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_apb_arbiter;

  localparam int N  = 2;
  localparam int AW = 13;
  localparam int DW = 32;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    m_psel, m_penable, m_pwrite;
  logic [N*AW-1:0] m_paddr;
  logic [N*DW-1:0] m_pwdata;
  logic [DW-1:0]   m_prdata;
  logic [N-1:0]    m_pready, m_pslverr;
  logic            s_psel, s_penable, s_pwrite;
  logic [AW-1:0]   s_paddr;
  logic [DW-1:0]   s_pwdata, s_prdata;
  logic            s_pready, s_pslverr;
  logic            grant_valid;
  logic [0:0]      grant_idx;

  always #5 PCLK = ~PCLK;

  apb_arbiter #(
    .NUM_MASTERS    (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .m_psel      (m_psel),
    .m_penable   (m_penable),
    .m_pwrite    (m_pwrite),
    .m_paddr     (m_paddr),
    .m_pwdata    (m_pwdata),
    .m_prdata    (m_prdata),
    .m_pready    (m_pready),
    .m_pslverr   (m_pslverr),
    .s_psel      (s_psel),
    .s_penable   (s_penable),
    .s_pwrite    (s_pwrite),
    .s_paddr     (s_paddr),
    .s_pwdata    (s_pwdata),
    .s_prdata    (s_prdata),
    .s_pready    (s_pready),
    .s_pslverr   (s_pslverr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // ---------------- slave model: memory with programmable wait states -----
  logic [DW-1:0] slave_mem [0:(1<<AW)-1] = '{default: '0};
  int            acc_cnt    = 0;
  int            slave_wait = 0;
  bit            slave_err  = 1'b0;
  bit            slave_hang = 1'b0;

  assign s_pready  = s_psel & s_penable & !slave_hang & (acc_cnt >= slave_wait);
  assign s_prdata  = slave_mem[s_paddr];
  assign s_pslverr = slave_err;

  always @(posedge PCLK) begin
    if (s_psel && s_penable) begin
      if (s_pready) begin
        acc_cnt <= 0;
        if (s_pwrite) slave_mem[s_paddr] <= s_pwdata;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // ---------------- reference model state ---------------------------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  int            ptr_m = 0;
  int            grant_log[$];

  // Master-side request state (one outstanding transfer per master).
  bit            busy      [N] = '{default: 1'b0};
  bit            pen       [N] = '{default: 1'b0};
  logic          req_write [N] = '{default: 1'b0};
  logic [AW-1:0] req_addr  [N] = '{default: '0};
  logic [DW-1:0] req_wdata [N] = '{default: '0};
  int            waited    [N] = '{default: 0};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          master;
    bit          write;
    logic [12:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      m_psel[i]            = busy[i];
      m_penable[i]         = busy[i] & pen[i];
      m_pwrite[i]          = req_write[i];
      m_paddr[i*AW +: AW]  = req_addr[i];
      m_pwdata[i*DW +: DW] = req_wdata[i];
    end
  endtask

  task automatic new_req(input int i, input bit rd_only);
    busy[i]      = 1'b1;
    pen[i]       = 1'b0;
    waited[i]    = 0;
    req_write[i] = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    req_addr[i]  = AW'($urandom_range(0, 15));
    req_wdata[i] = $urandom;
  endtask

  task automatic apply_reset();
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    for (int i = 0; i < N; i++) begin
      busy[i] = 1'b0; pen[i] = 1'b0; waited[i] = 0;
    end
    drive_masters();
    slave_hang = 1'b0; slave_wait = 0; slave_err = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    ptr_m = 0;
  endtask

  // One transfer from a lone requester with exact cycle-by-cycle checks.
  task automatic single_xfer(input vec_t v);
    int m;
    m = v.master;
    @(posedge PCLK); #1;
    for (int i = 0; i < N; i++) begin busy[i] = 1'b0; pen[i] = 1'b0; end
    busy[m] = 1'b1; req_write[m] = v.write; req_addr[m] = v.addr; req_wdata[m] = v.wdata;
    slave_wait = v.waits; slave_err = v.err;
    drive_masters();
    @(negedge PCLK);
    check("t0_no_slave_psel", s_psel, 0);
    @(posedge PCLK); #1;
    pen[m] = 1'b1;
    drive_masters();
    @(negedge PCLK);
    check("setup_psel", {s_psel, s_penable}, 2'b10);
    check("setup_grant", {grant_valid, grant_idx}, {1'b1, 1'(m)});
    check("setup_paddr", s_paddr, v.addr);
    check("setup_pwrite", s_pwrite, v.write);
    for (int c = 1; c <= v.waits + 1; c++) begin
      @(negedge PCLK);
      check("access_penable", s_penable, 1);
      if (c <= v.waits) begin
        check("wait_pready", m_pready, 0);
        check("wait_pslverr", m_pslverr, 0);
      end else begin
        check("done_pready", m_pready, 64'd1 << m);
        check("done_pslverr", m_pslverr, 64'(v.err) << m);
        if (v.write) check("done_pwdata", s_pwdata, v.wdata);
        else         check("done_prdata", m_prdata, v.exp_rdata);
      end
    end
    if (v.write) ref_mem[v.addr] = v.wdata;
    ptr_m = (m + 1) % N;
    @(posedge PCLK); #1;
    busy[m] = 1'b0; pen[m] = 1'b0;
    drive_masters();
    @(negedge PCLK);
    check("turnaround_idle", grant_valid, 0);
  endtask

  // Cycle-driven traffic engine. The expected winner is derived from the
  // requests seen in the arbitration cycle and the model's rr pointer.
  task automatic run_engine(input int max_cycles, input int target, input bit always_req, output int done);
    logic [N-1:0] prev_req;
    int cur_w, winner, c;
    done     = 0;
    cur_w    = -1;
    prev_req = m_psel;
    for (int cyc = 0; cyc < max_cycles && done < target; cyc++) begin
      @(negedge PCLK);
      if (s_psel && !s_penable) begin
        winner = -1;
        for (int k = 0; k < N; k++) begin
          c = (ptr_m + k) % N;
          if (winner < 0 && prev_req[c]) winner = c;
        end
        check("rr_winner_exists", winner >= 0, 1);
        if (winner >= 0) begin
          check("rr_grant_idx", grant_idx, winner);
          check("rr_setup_paddr", s_paddr, req_addr[winner]);
          check("rr_setup_pwrite", s_pwrite, req_write[winner]);
          if (req_write[winner]) check("rr_setup_pwdata", s_pwdata, req_wdata[winner]);
        end
        cur_w      = winner;
        slave_wait = $urandom_range(0, 3);
        slave_err  = ($urandom_range(0, 3) == 0);
      end
      if (m_pready != '0) begin
        if (cur_w < 0) begin
          check("spurious_pready", m_pready, 0);
        end else begin
          check("rr_pready_onehot", m_pready, 64'd1 << cur_w);
          check("rr_pslverr", m_pslverr, 64'(slave_err) << cur_w);
          if (req_write[cur_w]) ref_mem[req_addr[cur_w]] = req_wdata[cur_w];
          else check("rr_prdata", m_prdata, ref_mem[req_addr[cur_w]]);
          check("rr_fairness", waited[cur_w] <= N - 1, 1);
          for (int i = 0; i < N; i++) if (i != cur_w && busy[i]) waited[i]++;
          waited[cur_w] = 0;
          busy[cur_w]   = 1'b0;
          pen[cur_w]    = 1'b0;
          grant_log.push_back(cur_w);
          ptr_m = (cur_w + 1) % N;
          done++;
          cur_w = -1;
        end
      end
      prev_req = m_psel;
      @(posedge PCLK); #1;
      for (int i = 0; i < N; i++) begin
        if (busy[i]) pen[i] = 1'b1;
        else if (always_req || $urandom_range(0, 2) == 0) new_req(i, always_req);
      end
      drive_masters();
    end
  endtask

  initial begin
    int done;
    int acc;
    int exp_order [4] = '{0, 1, 0, 1};

    vecs[0] = '{0, 1'b1, 13'h004,  32'hDEADBEEF, 0, 1'b0, 32'h0};
    vecs[1] = '{1, 1'b1, 13'h008,  32'h12345678, 0, 1'b0, 32'h0};
    vecs[2] = '{0, 1'b0, 13'h008,  32'h0,        0, 1'b0, 32'h12345678};
    vecs[3] = '{1, 1'b0, 13'h004,  32'h0,        0, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{1, 1'b0, 13'h00C,  32'h0,        5, 1'b1, 32'h0};
    vecs[5] = '{0, 1'b1, 13'h1FFF, 32'hFFFFFFFF, 1, 1'b0, 32'h0};
    vecs[6] = '{1, 1'b0, 13'h1FFF, 32'h0,        2, 1'b0, 32'hFFFFFFFF};

    // Reset held with both masters requesting.
    PRESET = 1'b1;
    for (int i = 0; i < N; i++) begin busy[i] = 1'b1; pen[i] = 1'b0; end
    drive_masters();
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge PCLK);
      check("rst_s_psel", {s_psel, s_penable}, 0);
      check("rst_grant", {grant_valid, grant_idx}, 0);
      check("rst_m_pready", m_pready, 0);
      check("rst_m_pslverr", m_pslverr, 0);
      check("rst_s_paddr", s_paddr, 0);
      check("rst_s_pwdata", s_pwdata, 0);
      check("rst_m_prdata", m_prdata, 0);
    end
    @(posedge PCLK); #1;
    for (int i = 0; i < N; i++) busy[i] = 1'b0;
    drive_masters();
    PRESET = 1'b0;
    ptr_m  = 0;

    // Directed single-requester transfers.
    foreach (vecs[i]) single_xfer(vecs[i]);

    // Granted master drops PSEL during SETUP: slave completes, no response.
    @(posedge PCLK); #1;
    busy[0] = 1'b1; pen[0] = 1'b0; req_write[0] = 1'b1;
    req_addr[0] = 13'h020; req_wdata[0] = 32'hCAFEF00D;
    slave_wait = 0; slave_err = 1'b0;
    drive_masters();
    @(negedge PCLK);
    @(posedge PCLK); #1;
    busy[0] = 1'b0;
    drive_masters();
    @(negedge PCLK);
    check("drop_setup", {s_psel, s_penable, grant_idx}, 3'b100);
    @(negedge PCLK);
    check("drop_slave_access", {s_psel, s_penable}, 2'b11);
    check("drop_pready_suppressed", m_pready, 0);
    check("drop_pslverr_suppressed", m_pslverr, 0);
    ref_mem[13'h020] = 32'hCAFEF00D;
    @(negedge PCLK);
    check("drop_back_idle", grant_valid, 0);

    // Randomized traffic.
    apply_reset();
    grant_log.delete();
    run_engine(1500, 100000, 1'b0, done);
    check("random_progress", done >= 50, 1);

    // Continuous contention from pointer 0: strict alternation.
    apply_reset();
    for (int i = 0; i < N; i++) new_req(i, 1'b1);
    drive_masters();
    grant_log.delete();
    run_engine(100, 4, 1'b1, done);
    check("contention_count", done, 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) check("contention_order", grant_log[k], exp_order[k]);

    // Reset during a stalled ACCESS.
    apply_reset();
    new_req(1, 1'b1);
    slave_hang = 1'b1;
    drive_masters();
    acc = 0;
    for (int c = 0; c < 10 && acc == 0; c++) begin
      @(negedge PCLK);
      if (s_psel && s_penable) acc = 1;
    end
    check("midrst_reached_access", acc, 1);
    repeat (2) @(negedge PCLK);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    #1;
    check("midrst_s_psel_async", {s_psel, s_penable}, 0);
    check("midrst_grant", {grant_valid, grant_idx}, 0);
    check("midrst_pready", m_pready, 0);
    new_req(0, 1'b1);
    drive_masters();
    slave_hang = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    ptr_m  = 0;
    grant_log.delete();
    run_engine(40, 2, 1'b0, done);
    check("midrst_done", done, 2);
    if (grant_log.size() > 0) check("midrst_first_grant", grant_log[0], 0);

`ifdef APB_ARBITER_TIMEOUT_EN
    // Slave never readies: forced error completion after 8 wait cycles.
    apply_reset();
    new_req(0, 1'b1);
    new_req(1, 1'b1);
    slave_hang = 1'b1;
    drive_masters();
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      if (s_psel && s_penable) acc++;
      if (m_pready != '0) break;
    end
    check("tmo_access_cycles", acc, 9);
    check("tmo_pready", m_pready, 2'b01);
    check("tmo_pslverr", m_pslverr, 2'b01);
    @(posedge PCLK); #1;
    busy[0] = 1'b0;
    drive_masters();
    @(negedge PCLK);
    check("tmo_idle", {grant_valid, s_psel}, 0);
    @(negedge PCLK);
    check("tmo_next_grant", {s_psel, s_penable, grant_idx}, 3'b101);
    apply_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Shares one downstream APB slave port (e.g. the input of apb_converter) among NUM_MASTERS upstream APB masters.
- Arbitrates with round-robin priority and sequences the slave-side SETUP/ACCESS phases.
- Stalls non-granted masters via their PREADY and returns PRDATA/PSLVERR to the granted master only.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (2..8).
- APB_ADDR_WIDTH, 13, address width on both sides.
- APB_DATA_WIDTH, 32, data width on both sides.
- TIMEOUT_CYCLES, 64, ACCESS-phase watchdog limit (used only with the optional feature).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- m_psel  in  NUM_MASTERS  per-master PSEL.
- m_penable  in  NUM_MASTERS  per-master PENABLE.
- m_pwrite  in  NUM_MASTERS  per-master PWRITE.
- m_paddr  in  NUM_MASTERS*APB_ADDR_WIDTH  packed per-master PADDR; master i at bits [i*AW +: AW].
- m_pwdata  in  NUM_MASTERS*APB_DATA_WIDTH  packed per-master PWDATA.
- m_prdata  out  APB_DATA_WIDTH  shared read data; valid only for the master whose m_pready is high.
- m_pready  out  NUM_MASTERS  per-master PREADY.
- m_pslverr  out  NUM_MASTERS  per-master PSLVERR.
- s_psel, s_penable, s_pwrite  out  1 each  slave-side control.
- s_paddr  out  APB_ADDR_WIDTH  slave-side PADDR.
- s_pwdata  out  APB_DATA_WIDTH  slave-side PWDATA.
- s_prdata  in  APB_DATA_WIDTH  slave-side PRDATA.
- s_pready, s_pslverr  in  1 each  slave-side PREADY and PSLVERR.
- grant_valid  out  1  a transfer is owned (state SETUP or ACCESS).
- grant_idx  out  $clog2(NUM_MASTERS) (min 1)  index of the owning master.

Behaviour:
- FSM has three states: IDLE, SETUP, ACCESS.
- Reset: state=IDLE, rr pointer=0, grant_idx=0, grant_valid=0, every m_pready/m_pslverr=0, s_psel=s_penable=0. m_prdata and s_* buses are 0 while not granted.
- A request is m_psel[i]=1.
- IDLE: if any request is present, pick the first requester at or after the rr pointer (cyclic), register grant_idx, and go to SETUP. No request: stay in IDLE.
- SETUP (1 cycle): s_psel=1, s_penable=0; s_pwrite/s_paddr/s_pwdata are muxed combinationally from master grant_idx. Always go to ACCESS.
- ACCESS: s_psel=1, s_penable=1.
  - m_pready[grant_idx]=s_pready.
  - m_pslverr[grant_idx]=s_pready & s_pslverr.
  - m_prdata=s_prdata (combinational).
  - When s_pready=1: rr pointer=(grant_idx+1) mod NUM_MASTERS, go to IDLE.
- Latency: master SETUP at cycle t0 while IDLE gives slave SETUP at t1, slave ACCESS at t2. With a zero-wait slave, master completes at t2. Minimum 3 cycles per transfer, including 1 IDLE turnaround.
- Non-granted masters see m_pready=0 and m_pslverr=0 and stall legally.
- A master may drop m_psel while waiting; the arbiter then ignores it.
- Granted master drops m_psel during SETUP/ACCESS (protocol violation): slave transfer still completes, and the response is suppressed (m_pready not driven to that master).
- Multiple simultaneous requests: exactly one grant per transfer, strict round-robin; no master waits more than NUM_MASTERS-1 transfers.
- Single requester: it is granted back-to-back, one transfer per 3+ cycles.
- PRESET asserted mid-transfer: immediate return to reset values; the slave sees s_psel drop asynchronously.

Optional Feature:
- Macro: APB_ARBITER_TIMEOUT_EN.
- Defined: a counter starts at 0 on entry to ACCESS and increments each ACCESS cycle without s_pready. When it reaches TIMEOUT_CYCLES, the arbiter drives m_pready[grant_idx]=1 and m_pslverr[grant_idx]=1 for one cycle, deasserts s_psel/s_penable next cycle, advances the pointer, and goes to IDLE.
- Not defined: no counter; ACCESS waits indefinitely for s_pready.

Decomposition:
- Package apb_arbiter_pkg: state enum (IDLE/SETUP/ACCESS) and width helper constants (grant index width, timeout counter width).
- Sub-module rr_arbiter: combinational round-robin pick from request vector plus pointer, returning index and valid. The pointer register lives in the parent.

Test Plan:
- Reset: hold PRESET=1 for 3 cycles with m_psel=2'b11 -> all outputs 0, no s_psel.
- Single write: master 0 writes addr 0x004, data 0xDEADBEEF, slave zero-wait -> s_psel at t1, s_penable at t2 with s_paddr=0x004 and s_pwdata=0xDEADBEEF; m_pready[0]=1 at t2; m_pready[1] stays 0.
- Contention: both masters request continuously from the pointer=0 state -> grant order 0,1,0,1 over 4 transfers; reads return memory-model data to the correct master only.
- Wait states: slave holds s_pready=0 for 5 cycles, then s_pready=1 with s_pslverr=1 -> m_pready and m_pslverr for the granted master pulse together in cycle 6 of ACCESS.
- Reset mid-ACCESS: assert PRESET during wait -> s_psel=0 immediately, next grant after release goes to master 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): slave never readies -> m_pready=1 and m_pslverr=1 after 8 ACCESS cycles, FSM returns to IDLE, next master is granted.
